fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded by reset.
REQ-002 Parameter retired-counter width CNT_W, default 32, sets the width of retired_cnt.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  byte address of the requested word; equals pc.
REQ-007 imem_ack  input  1  memory has placed valid data on imem_rdata this cycle.
REQ-008 imem_rdata  input  32  instruction word from memory.
REQ-009 instr  output  32  held instruction for the execute stage.
REQ-010 opcode  output  6  instr[31:26]; this drives the decoder's opcode input.
REQ-011 instr_valid  output  1  instr is valid and executing.
REQ-012 pc  output  32  address of the current instruction.
REQ-013 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-014 branch  input  1  from the decoder; instruction is BEQ.
REQ-015 jump  input  1  from the decoder; instruction is J.
REQ-016 zero  input  1  ALU zero flag for the current instruction.
REQ-017 advance  input  1  datapath has completed the current instruction.
REQ-018 retired_cnt  output  CNT_W  count of retired instructions.

Function
REQ-019 The FSM SHALL have two states: FETCH and EXEC.
REQ-020 In FETCH, the block SHALL assert imem_req = 1 with imem_addr = pc and SHALL hold instr_valid = 0.
REQ-021 In FETCH with imem_ack = 1, the block SHALL capture imem_rdata into instr and move to EXEC on the next edge; acknowledge in the same cycle the request is raised is legal, giving minimum fetch latency 1 cycle.
REQ-022 In FETCH with imem_ack = 0, the block SHALL hold its state, pc and request, with no timeout.
REQ-023 In EXEC, the block SHALL hold imem_req = 0 and instr_valid = 1; instr and pc SHALL be stable.
REQ-024 In EXEC with advance = 1, the block SHALL load pc with next_pc, increment retired_cnt and return to FETCH.
REQ-025 In EXEC with advance = 0, the block SHALL hold all state.
REQ-026 next_pc priority: jump = 1 gives {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-027 next_pc priority: else branch & zero gives pc_plus4 + (sign-extended instr[15:0] << 2).
REQ-028 next_pc priority: otherwise next_pc is pc_plus4.
REQ-029 All PC arithmetic SHALL be 32-bit modulo 2^32; pc 32'hFFFF_FFFC sequential wraps to 32'h0.
REQ-030 If jump and branch are both 1, jump SHALL win.
REQ-031 imem_ack outside FETCH SHALL be ignored and SHALL NOT alter instr.
REQ-032 advance outside EXEC SHALL be ignored.
REQ-033 retired_cnt SHALL wrap from all-ones to 0.
REQ-034 The opcode output SHALL be combinational from the instr register; it SHALL be meaningful only when instr_valid = 1.

Reset
REQ-035 Asserting reset at any time, including mid-fetch, SHALL immediately set state = FETCH, pc = RESET_PC, instr = 32'h0, and retired_cnt = 0.
REQ-036 While reset is asserted, the block SHALL force imem_req = 0 and instr_valid = 0; a pending fetch is abandoned.
REQ-037 On the first clk edge after reset deasserts, the block SHALL raise imem_req with imem_addr = RESET_PC.

Structure
REQ-038 A shared package mips_pkg SHALL hold the opcode constants (R-type 6'h00, LW 6'h23, SW 6'h2B, BEQ 6'h04, J 6'h02), the fetch state enum and RESET_PC default.
REQ-039 One sub-module, pc_next, SHALL be combinational: inputs pc_plus4, instr, branch, jump, zero; output next_pc.
REQ-040 The FSM, pc, instr and counter registers SHALL live in fetch_unit.

Verification
REQ-041 Sequential fetch: reset, then ack after 2 cycles with 32'h0000_0020, then advance -> pc 0 -> 4, retired_cnt = 1, and instr_valid rises exactly 1 cycle after ack.
REQ-042 Taken branch: pc = 32'h10, instr imm 16'hFFFE, branch = 1, zero = 1, advance -> pc = 32'h0C; with zero = 0 -> pc = 32'h14.
REQ-043 Jump: pc = 32'h4000_0010, instr[25:0] = 26'h000_0040, jump = 1 and branch = 1, advance -> pc = 32'h4000_0100.
REQ-044 Stalls: hold advance = 0 for 5 cycles and keep imem_ack = 0 for 7 cycles -> pc, instr and imem_addr unchanged throughout; no retire.
REQ-045 Reset mid-fetch: assert reset while imem_req = 1 with pc = 32'h40 -> imem_req = 0 the same cycle; after release, imem_addr = RESET_PC and retired_cnt = 0.
REQ-046 Spurious ack and wrap: ack in EXEC with 32'hDEAD_BEEF leaves instr unchanged; sequential from pc 32'hFFFF_FFFC gives pc = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode constants, fetch FSM states and the default reset PC.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection for the fetch unit: jump over taken branch over sequential.
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;
  logic [5:0]  w_unused_opcode;

  // The opcode field plays no part in target arithmetic; the decoder already resolved it.
  assign w_unused_opcode = instr[31:26];

  assign w_jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign w_branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    if (jump)
      next_pc = w_jump_target;
    else if (branch && zero)
      next_pc = w_branch_target;
    else
      next_pc = pc_plus4;
  end

endmodule

// File: rtl/fetch_unit.sv
// Two-state instruction fetch unit: requests a word at pc, holds it for execute,
// and steps pc when the datapath signals completion.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [5:0]       opcode,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             branch,
  input  logic             jump,
  input  logic             zero,
  input  logic             advance,
  output logic [CNT_W-1:0] retired_cnt
);

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_retired_cnt;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_next_pc;
  logic             w_capture;
  logic             w_retire;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_capture  = (r_state == ST_FETCH) && imem_ack;
  assign w_retire   = (r_state == ST_EXEC) && advance;

  pc_next u_pc_next (
    .pc_plus4 (w_pc_plus4),
    .instr    (r_instr),
    .branch   (branch),
    .jump     (jump),
    .zero     (zero),
    .next_pc  (w_next_pc)
  );

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ST_FETCH;
    else
      r_state <= w_state_next;
  end

  // NOTE: default assignment first so no path leaves w_state_next unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_FETCH: if (imem_ack) w_state_next = ST_EXEC;
      ST_EXEC:  if (advance)  w_state_next = ST_FETCH;
      default:  w_state_next = ST_FETCH;
    endcase
  end

  // Reset gates the request combinationally so a pending fetch drops in the same cycle.
  always_comb begin
    imem_req    = (r_state == ST_FETCH) && !reset;
    instr_valid = (r_state == ST_EXEC) && !reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_retired_cnt <= '0;
    end else begin
      if (w_capture)
        r_instr <= imem_rdata;
      if (w_retire) begin
        r_pc          <= w_next_pc;
        r_retired_cnt <= r_retired_cnt + CNT_W'(1);
      end
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:26];
  assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; a second instance with a high reset PC and a
// 2-bit retire counter covers the jump region and counter wrap.
module tb_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic        advance = 1'b0;

  logic        imem_req,  imem_req_j;
  logic [31:0] imem_addr, imem_addr_j;
  logic [31:0] instr,     instr_j;
  logic [5:0]  opcode,    opcode_j;
  logic        instr_valid, instr_valid_j;
  logic [31:0] pc,        pc_j;
  logic [31:0] pc_plus4,  pc_plus4_j;
  logic [31:0] retired_cnt;
  logic [1:0]  retired_cnt_j;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .branch(branch),
    .jump(jump), .zero(zero), .advance(advance), .retired_cnt(retired_cnt)
  );

  fetch_unit #(.RESET_PC(32'h4000_0010), .CNT_W(2)) dut_j (
    .clk(clk), .reset(reset), .imem_req(imem_req_j), .imem_addr(imem_addr_j),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr_j), .opcode(opcode_j),
    .instr_valid(instr_valid_j), .pc(pc_j), .pc_plus4(pc_plus4_j), .branch(branch),
    .jump(jump), .zero(zero), .advance(advance), .retired_cnt(retired_cnt_j)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: immediate ack, then a single EXEC cycle with the given decode flags.
  task automatic fetch_exec(input logic [31:0] word, input logic br, input logic jp, input logic z);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("fx_valid", {31'b0, instr_valid}, 32'd1);
    check("fx_instr", instr, word);
    branch  = br;
    jump    = jp;
    zero    = z;
    advance = 1'b1;
    step();
    advance = 1'b0;
    branch  = 1'b0;
    jump    = 1'b0;
    zero    = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_cnt", retired_cnt, 32'd0);
    check("rst_pc_j", pc_j, 32'h4000_0010);
    reset = 1'b0;
    step();
    check("post_rst_req", {31'b0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    check("pc_plus4", pc_plus4, 32'h4);

    // Sequential fetch with delayed ack
    step();
    check("wait_req", {31'b0, imem_req}, 32'd1);
    check("wait_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0020;
    #1;
    check("ack_cycle_valid", {31'b0, instr_valid}, 32'd0);
    step();
    imem_ack = 1'b0;
    check("seq_valid", {31'b0, instr_valid}, 32'd1);
    check("seq_instr", instr, 32'h0000_0020);
    check("seq_req_exec", {31'b0, imem_req}, 32'd0);
    check("seq_opcode", {26'b0, opcode}, {26'b0, OP_RTYPE});
    advance = 1'b1;
    step();
    advance = 1'b0;
    check("seq_pc", pc, 32'h4);
    check("seq_cnt", retired_cnt, 32'd1);
    check("seq_req_back", {31'b0, imem_req}, 32'd1);
    check("seq_valid_drop", {31'b0, instr_valid}, 32'd0);

    // Walk to pc 0x10, then taken and not-taken branch
    for (int i = 0; i < 3; i++) fetch_exec(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    check("walk_pc", pc, 32'h10);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1022_FFFE;
    step();
    imem_ack = 1'b0;
    check("beq_opcode", {26'b0, opcode}, {26'b0, OP_BEQ});
    branch = 1'b1; zero = 1'b1; advance = 1'b1;
    step();
    branch = 1'b0; zero = 1'b0; advance = 1'b0;
    check("beq_taken_pc", pc, 32'h0000_000C);
    fetch_exec(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    fetch_exec(32'h1022_FFFE, 1'b1, 1'b0, 1'b0);
    check("beq_not_taken_pc", pc, 32'h0000_0014);
    check("beq_cnt", retired_cnt, 32'd7);

    // Fetch stall for 7 cycles with advance ignored outside EXEC
    imem_ack = 1'b0;
    advance  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("fstall_pc", pc, 32'h14);
      check("fstall_addr", imem_addr, 32'h14);
      check("fstall_req", {31'b0, imem_req}, 32'd1);
      check("fstall_cnt", retired_cnt, 32'd7);
    end
    advance = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0020;
    step();
    imem_ack   = 1'b0;
    // Execute stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("xstall_pc", pc, 32'h14);
      check("xstall_instr", instr, 32'h0000_0020);
      check("xstall_valid", {31'b0, instr_valid}, 32'd1);
      check("xstall_cnt", retired_cnt, 32'd7);
    end
    // Spurious ack in EXEC
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack   = 1'b0;
    check("spurious_instr", instr, 32'h0000_0020);
    check("spurious_valid", {31'b0, instr_valid}, 32'd1);
    advance = 1'b1;
    step();
    advance = 1'b0;
    check("after_stall_pc", pc, 32'h18);

    // Branch forward to 0x40, then reset mid-fetch
    fetch_exec(32'h1000_0009, 1'b1, 1'b0, 1'b1);
    check("fwd_pc", pc, 32'h40);
    check("fwd_req", {31'b0, imem_req}, 32'd1);
    check("fwd_cnt", retired_cnt, 32'd9);
    reset = 1'b1;
    #1;
    check("midrst_req", {31'b0, imem_req}, 32'd0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_cnt", retired_cnt, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("rel_addr", imem_addr, 32'h0);
    check("rel_cnt", retired_cnt, 32'd0);
    step();
    check("rel_req", {31'b0, imem_req}, 32'd1);
    check("rel_addr_j", imem_addr_j, 32'h4000_0010);

    // Jump wins over branch
    fetch_exec({OP_J, 26'h000_0040}, 1'b1, 1'b1, 1'b1);
    check("jump_pc_j", pc_j, 32'h4000_0100);
    check("jump_pc", pc, 32'h0000_0100);

    // Branch back to 0xFFFF_FFFC, then sequential wrap to 0
    fetch_exec(32'h1000_FFBE, 1'b1, 1'b0, 1'b1);
    check("back_pc", pc, 32'hFFFF_FFFC);
    check("back_plus4", pc_plus4, 32'h0);
    fetch_exec(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    check("wrap_pc", pc, 32'h0);
    check("cnt_j_3", {30'b0, retired_cnt_j}, 32'd3);
    fetch_exec(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    check("cnt_j_wrap", {30'b0, retired_cnt_j}, 32'd0);
    check("cnt_main", retired_cnt, 32'd4);
    check("final_pc", pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
